// File: rtl/aes_mmio_cmd_issuer.sv
// Programs one AES job over byte-wide MMIO (37 writes, then status polls); first stb 1 cycle after job_start.
// Each transaction is held until mmio_ack, with one stb-low cycle after it; a missing ack aborts the job.
module aes_mmio_cmd_issuer #(
    parameter int POLL_GAP    = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int MAX_POLLS   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_start,
    input  logic [15:0]  job_xaddr,
    input  logic [15:0]  job_len,
    input  logic [127:0] job_key,
    input  logic [127:0] job_ctr,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         mmio_stb,
    output logic         mmio_wr,
    output logic [15:0]  mmio_addr,
    output logic [7:0]   mmio_wdata,
    input  logic         mmio_ack,
    input  logic [7:0]   mmio_rdata
);
    localparam logic [15:0] GAP_LAST  = (POLL_GAP > 1) ? 16'(POLL_GAP - 1) : 16'd0;
    localparam logic [7:0]  TO_LAST   = 8'(ACK_TIMEOUT - 1);
    localparam logic [10:0] POLL_LAST = 11'(MAX_POLLS - 1);

    typedef enum logic [2:0] {IDLE, WR, GAP, POLL, DONE} state_t;

    state_t        state;
    logic [15:0]   xaddr_q, len_q;
    logic [127:0]  key_q, ctr_q;
    logic [5:0]    idx;
    logic [7:0]    to_cnt;
    logic [10:0]   poll_cnt;
    logic [15:0]   gap_cnt;
    logic [15:0]   cur_addr;
    logic [7:0]    cur_data;
    logic [5:0]    off;
    logic          to_hit;
    logic          unused_rdata;

    assign unused_rdata = ^mmio_rdata[7:2];
    assign to_hit = mmio_stb && !mmio_ack && (to_cnt == TO_LAST);

    // Address/data of write idx, taken from the job fields latched at start.
    always_comb begin
        cur_addr = 16'hff00;
        cur_data = 8'h01;
        off      = 6'd0;
        if (idx < 6'd4) begin
            cur_addr = 16'hff02 + {10'd0, idx};
            case (idx[1:0])
                2'd0:    cur_data = xaddr_q[7:0];
                2'd1:    cur_data = xaddr_q[15:8];
                2'd2:    cur_data = len_q[7:0];
                default: cur_data = len_q[15:8];
            endcase
        end else if (idx < 6'd20) begin
            off      = idx - 6'd4;
            cur_addr = 16'hff10 + {10'd0, off};
            cur_data = key_q[{off[3:0], 3'b000} +: 8];
        end else if (idx < 6'd36) begin
            off      = idx - 6'd20;
            cur_addr = 16'hff20 + {10'd0, off};
            cur_data = ctr_q[{off[3:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mmio_stb   <= 1'b0;
            mmio_wr    <= 1'b0;
            mmio_addr  <= 16'd0;
            mmio_wdata <= 8'd0;
            xaddr_q    <= 16'd0;
            len_q      <= 16'd0;
            key_q      <= 128'd0;
            ctr_q      <= 128'd0;
            idx        <= 6'd0;
            to_cnt     <= 8'd0;
            poll_cnt   <= 11'd0;
            gap_cnt    <= 16'd0;
        end else begin
            done <= 1'b0;
            if (mmio_stb && !mmio_ack) to_cnt <= to_cnt + 8'd1;
            else                       to_cnt <= 8'd0;

            if (to_hit) begin
                mmio_stb <= 1'b0;
                err      <= 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= DONE;
            end else begin
                case (state)
                    IDLE: if (job_start) begin
                        xaddr_q    <= job_xaddr;
                        len_q      <= job_len;
                        key_q      <= job_key;
                        ctr_q      <= job_ctr;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        idx        <= 6'd0;
                        poll_cnt   <= 11'd0;
                        mmio_stb   <= 1'b1;
                        mmio_wr    <= 1'b1;
                        mmio_addr  <= 16'hff02;
                        mmio_wdata <= job_xaddr[7:0];
                        state      <= WR;
                    end
                    WR: if (mmio_stb) begin
                        if (mmio_ack) begin
                            mmio_stb <= 1'b0;
                            if (idx == 6'd36) begin
                                gap_cnt <= 16'd0;
                                state   <= GAP;
                            end else begin
                                idx <= idx + 6'd1;
                            end
                        end
                    end else begin
                        mmio_stb   <= 1'b1;
                        mmio_wr    <= 1'b1;
                        mmio_addr  <= cur_addr;
                        mmio_wdata <= cur_data;
                    end
                    GAP: if (gap_cnt == GAP_LAST) begin
                        mmio_stb  <= 1'b1;
                        mmio_wr   <= 1'b0;
                        mmio_addr <= 16'hff01;
                        state     <= POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                    POLL: if (mmio_stb && mmio_ack) begin
                        mmio_stb <= 1'b0;
                        if (mmio_rdata[1:0] == 2'b00 || poll_cnt == POLL_LAST) begin
                            err   <= (mmio_rdata[1:0] != 2'b00);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            poll_cnt <= poll_cnt + 11'd1;
                            gap_cnt  <= 16'd0;
                            state    <= GAP;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
